// File: rtl/la_capture.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : la_capture
// Brief    : Logic-analyzer capture engine that streams probe samples into a
//            pair of SQI SRAMs, with a mask/pattern trigger and a post-trigger
//            sample count.
// Revision : 1.0 - initial release
// ============================================================================
module la_capture #(
    parameter int LA_WIDTH   = 8,
    parameter int CNT_WIDTH  = 23,
    parameter int ADDR_WIDTH = 18
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  arm,
    input  logic                  abort,
    input  logic [LA_WIDTH-1:0]   trig_mask,
    input  logic [LA_WIDTH-1:0]   trig_pattern,
    input  logic [CNT_WIDTH-1:0]  samples_post,
    input  logic [LA_WIDTH-1:0]   lat,
    output logic [1:0]            sram_cs,
    output logic                  sram_clk_en,
    output logic                  sram_oe,
    output logic [LA_WIDTH-1:0]   sram_dout,
    output logic                  busy,
    output logic                  triggered,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] trig_addr,
    output logic [ADDR_WIDTH-1:0] wr_addr
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CMD  = 3'd1,
        S_ADDR = 3'd2,
        S_PRE  = 3'd3,
        S_POST = 3'd4,
        S_DONE = 3'd5
    } state_t;

    // Both chips receive the same nibble, so the write command is duplicated.
    localparam logic [LA_WIDTH-1:0] CMD_WRITE_NIB = LA_WIDTH'(8'h22);
    localparam logic [2:0]          CMD_LAST      = 3'd1;
    localparam logic [2:0]          ADDR_LAST     = 3'd5;

    state_t                state_q;
    logic [2:0]            step_q;
    logic [CNT_WIDTH-1:0]  post_cnt_q;
    logic [1:0]            cs_q;
    logic                  clk_en_q;
    logic                  oe_q;
    logic                  busy_q;
    logic                  triggered_q;
    logic                  done_q;
    logic [LA_WIDTH-1:0]   dout_q;
    logic [ADDR_WIDTH-1:0] trig_addr_q;
    logic [ADDR_WIDTH-1:0] wr_addr_q;
    logic                  trig_match;

    assign trig_match = ((lat ^ trig_pattern) & trig_mask) == '0;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            step_q      <= '0;
            post_cnt_q  <= '0;
            cs_q        <= 2'b11;
            clk_en_q    <= 1'b0;
            oe_q        <= 1'b0;
            busy_q      <= 1'b0;
            triggered_q <= 1'b0;
            done_q      <= 1'b0;
            dout_q      <= '0;
            trig_addr_q <= '0;
            wr_addr_q   <= '0;
        end else if (abort) begin
            // triggered, trig_addr and wr_addr survive so the host can inspect them.
            state_q  <= S_IDLE;
            step_q   <= '0;
            cs_q     <= 2'b11;
            clk_en_q <= 1'b0;
            oe_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dout_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (arm) begin
                        state_q     <= S_CMD;
                        step_q      <= '0;
                        post_cnt_q  <= '0;
                        cs_q        <= 2'b00;
                        clk_en_q    <= 1'b1;
                        oe_q        <= 1'b1;
                        busy_q      <= 1'b1;
                        triggered_q <= 1'b0;
                        done_q      <= 1'b0;
                        dout_q      <= '0;
                        wr_addr_q   <= '0;
                    end
                end
                S_CMD: begin
                    if (step_q == CMD_LAST) begin
                        state_q <= S_ADDR;
                        step_q  <= '0;
                        dout_q  <= '0;
                    end else begin
                        step_q  <= step_q + 3'd1;
                        dout_q  <= CMD_WRITE_NIB;
                    end
                end
                S_ADDR: begin
                    dout_q <= '0;
                    if (step_q == ADDR_LAST) begin
                        state_q <= S_PRE;
                        step_q  <= '0;
                    end else begin
                        step_q  <= step_q + 3'd1;
                    end
                end
                S_PRE: begin
                    dout_q    <= lat;
                    wr_addr_q <= wr_addr_q + 1'b1;
                    if (trig_match) begin
                        state_q     <= S_POST;
                        triggered_q <= 1'b1;
                        trig_addr_q <= wr_addr_q;
                        post_cnt_q  <= '0;
                    end
                end
                S_POST: begin
                    dout_q    <= lat;
                    wr_addr_q <= wr_addr_q + 1'b1;
                    if (post_cnt_q == samples_post) begin
                        state_q  <= S_DONE;
                        cs_q     <= 2'b11;
                        clk_en_q <= 1'b0;
                        oe_q     <= 1'b0;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                    end else begin
                        post_cnt_q <= post_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q  <= S_IDLE;
                    cs_q     <= 2'b11;
                    clk_en_q <= 1'b0;
                    oe_q     <= 1'b0;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

    assign sram_cs     = cs_q;
    assign sram_clk_en = clk_en_q;
    assign sram_oe     = oe_q;
    assign sram_dout   = dout_q;
    assign busy        = busy_q;
    assign triggered   = triggered_q;
    assign done        = done_q;
    assign trig_addr   = trig_addr_q;
    assign wr_addr     = wr_addr_q;

endmodule
`default_nettype wire

// File: tb/tb_la_capture.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_la_capture
// Brief    : Self-checking bench for la_capture: per-cycle timeline model of
//            the SRAM pin stream plus abort/reset corner sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_la_capture;

    localparam int LW    = 8;
    localparam int CW    = 23;
    localparam int AW    = 10;   // narrow address so the wrap case stays short
    localparam int AMOD  = 1 << AW;
    localparam int LIMIT = 3000;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          arm;
    logic          abort;
    logic [LW-1:0] trig_mask;
    logic [LW-1:0] trig_pattern;
    logic [CW-1:0] samples_post;
    logic [LW-1:0] lat;
    logic [1:0]    sram_cs;
    logic          sram_clk_en;
    logic          sram_oe;
    logic [LW-1:0] sram_dout;
    logic          busy;
    logic          triggered;
    logic          done;
    logic [AW-1:0] trig_addr;
    logic [AW-1:0] wr_addr;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    la_capture #(
        .LA_WIDTH   (LW),
        .CNT_WIDTH  (CW),
        .ADDR_WIDTH (AW)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .arm          (arm),
        .abort        (abort),
        .trig_mask    (trig_mask),
        .trig_pattern (trig_pattern),
        .samples_post (samples_post),
        .lat          (lat),
        .sram_cs      (sram_cs),
        .sram_clk_en  (sram_clk_en),
        .sram_oe      (sram_oe),
        .sram_dout    (sram_dout),
        .busy         (busy),
        .triggered    (triggered),
        .done         (done),
        .trig_addr    (trig_addr),
        .wr_addr      (wr_addr)
    );

    // {cs[34:33], clk_en[32], oe[31], busy[30], triggered[29], done[28],
    //  dout[27:20], wr_addr[19:10], trig_addr[9:0]}
    localparam logic [34:0] CARE_ALL  = {35{1'b1}};
    localparam logic [34:0] CARE_NOTA = {{25{1'b1}}, 10'b0};
    localparam logic [34:0] CARE_IDLE = {{15{1'b1}}, 20'b0};

    typedef struct {
        logic [7:0] mask;
        logic [7:0] pat;
        int         sp;
        int         rise;     // <0: fully random lat, else bit0 rises at this sample
        int         rearm;    // cycle at which a stray arm pulse is injected
        int         exp_ta;   // <0: rely on the model only
        int         exp_wr;
        int         exp_en;
    } run_t;

    function automatic logic [34:0] pk(input logic [1:0] cs, input logic en, input logic oe,
                                       input logic bz, input logic tg, input logic dn,
                                       input logic [7:0] d, input logic [9:0] wa,
                                       input logic [9:0] ta);
        return {cs, en, oe, bz, tg, dn, d, wa, ta};
    endfunction

    function automatic logic [34:0] snap();
        return {sram_cs, sram_clk_en, sram_oe, busy, triggered, done, sram_dout, wr_addr, trig_addr};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [34:0] act,
                         input logic [34:0] exp, input logic [34:0] care);
        n_cmp++;
        if (((act ^ exp) & care) != 35'd0) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (care %h)", name, act, exp, care);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Timeline model: cycles 0..1 command nibbles, 2..7 address nibbles,
    // sample s is taken in cycle 8+s and shows on the pins in cycle 9+s;
    // the trigger at sample t is followed by sp+1 samples, then DONE.
    task automatic do_run(input run_t r, input int idx);
        logic [7:0]  lq[$];
        logic [7:0]  l;
        logic [34:0] e;
        logic [34:0] care;
        int          trig;
        int          endk;
        int          k;
        int          en_cnt;
        bit          fin;
        bit          tg;
        trig   = -1;
        endk   = -1;
        k      = 0;
        en_cnt = 0;
        fin    = 1'b0;
        trig_mask    = r.mask;
        trig_pattern = r.pat;
        samples_post = CW'(r.sp);
        arm = 1'b1;
        tick();
        arm = 1'b0;
        while (k < LIMIT) begin
            fin  = (endk >= 0) && (k == endk);
            tg   = (trig >= 0) && (k > 8 + trig);
            e    = pk(fin ? 2'b11 : 2'b00, !fin, !fin, !fin, tg, fin,
                      (k == 1) ? 8'h22 : (k <= 8) ? 8'h00 : lq[k-9],
                      (k <= 8) ? 10'd0 : 10'((k - 8) % AMOD),
                      (trig >= 0) ? 10'(trig % AMOD) : 10'd0);
            care = tg ? CARE_ALL : CARE_NOTA;
            check($sformatf("run%0d cyc%0d", idx, k), snap(), e, care);
            if (sram_clk_en) en_cnt++;
            if (fin) break;
            arm = (k == r.rearm);
            l = 8'($urandom);
            if (k >= 8) begin
                if (r.rise >= 0) l[0] = (k - 8 >= r.rise);
                lq.push_back(l);
                if (trig < 0 && ((l ^ r.pat) & r.mask) == 8'h00) begin
                    trig = k - 8;
                    endk = k + r.sp + 2;
                end
            end
            lat = l;
            tick();
            k++;
        end
        arm = 1'b0;
        if (!fin) begin
            n_cmp++;
            n_bad++;
            $display("FAIL run%0d timeout: got no DONE within %0d cycles, required DONE", idx, LIMIT);
        end else begin
            check_int($sformatf("run%0d clk_en cycles", idx), en_cnt, endk);
            if (r.exp_ta >= 0) begin
                check_int($sformatf("run%0d trig_addr", idx), int'(trig_addr), r.exp_ta);
                check_int($sformatf("run%0d wr_addr", idx), int'(wr_addr), r.exp_wr);
                check_int($sformatf("run%0d clk_en table", idx), en_cnt, r.exp_en);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no end of test, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        run_t tbl[5];
        run_t rr;
        logic [34:0] rst_v;
        tbl[0] = '{8'h00, 8'h00, 3, -1,   -1, 0, 5, 13};
        tbl[1] = '{8'h01, 8'h01, 4, 9,    -1, 9, 15, 23};
        tbl[2] = '{8'h01, 8'h01, 0, 0,    -1, 0, 2, 10};
        tbl[3] = '{8'h00, 8'h00, 3, -1,    3, 0, 5, 13};
        tbl[4] = '{8'h01, 8'h01, 2, 1026, -1, 2, 6, 1038};
        rst_v  = pk(2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 10'd0, 10'd0);

        reset_n = 1'b0; arm = 1'b0; abort = 1'b0;
        trig_mask = '0; trig_pattern = '0; samples_post = '0; lat = '0;
        repeat (3) tick();
        check("reset values", snap(), rst_v, CARE_ALL);
        reset_n = 1'b1;
        tick();
        check("idle after reset", snap(), rst_v, CARE_ALL);

        for (int i = 0; i < 5; i++) do_run(tbl[i], i);

        for (int i = 0; i < 6; i++) begin
            rr.mask  = 8'($urandom & $urandom & $urandom);
            rr.pat   = 8'($urandom);
            rr.sp    = int'($urandom_range(0, 20));
            rr.rise  = -1;
            rr.rearm = int'($urandom_range(0, 30));
            rr.exp_ta = -1; rr.exp_wr = -1; rr.exp_en = -1;
            do_run(rr, 10 + i);
        end

        // abort during ADDR
        trig_mask = '0; samples_post = CW'(3);
        arm = 1'b1; tick(); arm = 1'b0;
        repeat (3) tick();
        abort = 1'b1; tick(); abort = 1'b0;
        check("abort in ADDR", snap(), rst_v, CARE_IDLE);
        tick();
        check("idle after ADDR abort", snap(), rst_v, CARE_IDLE);

        // abort during POST keeps triggered and trig_addr
        samples_post = CW'(20);
        arm = 1'b1; tick(); arm = 1'b0;
        repeat (12) tick();
        abort = 1'b1; tick(); abort = 1'b0;
        check("abort in POST", snap(),
              pk(2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 10'd0, 10'd0), CARE_IDLE);
        check_int("trig_addr after POST abort", int'(trig_addr), 0);

        // arm and abort together: abort wins
        arm = 1'b1; abort = 1'b1; tick(); arm = 1'b0; abort = 1'b0;
        check("arm+abort stays idle", snap(),
              pk(2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 10'd0, 10'd0), CARE_IDLE);
        tick();
        check("arm+abort still idle", snap(),
              pk(2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 10'd0, 10'd0), CARE_IDLE);

        // asynchronous reset mid-POST, then a normal run
        arm = 1'b1; tick(); arm = 1'b0;
        repeat (11) tick();
        #3 reset_n = 1'b0;
        #1 check("async reset mid-POST", snap(), rst_v, CARE_ALL);
        tick();
        reset_n = 1'b1;
        tick();
        check("idle after mid-run reset", snap(), rst_v, CARE_ALL);
        do_run(tbl[0], 20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
